// File: rtl/mem_stage_if.sv
// EX->MEM->WB boundary bundle for mem_stage: EX result in, WB result and branch redirect out.
// Latency: n/a (wires only); mem_stage registers every output except STALL.
// Backpressure: STALL is the only upstream hold; the WB side has no ready and always accepts.
interface mem_stage_if;
  // EX side
  logic        V_EX;
  logic [15:0] RESULT;
  logic [1:0]  OP_EX_RETURN;
  logic [2:0]  DR_EX_RETURN;
  logic [2:0]  CC;
  logic [15:0] STORE_DATA;
  logic        FLUSH;
  logic        STALL;
  // WB side and branch redirect
  logic        V_MEM;
  logic [1:0]  OP_MEM;
  logic [2:0]  DR_MEM;
  logic [15:0] DATA_MEM;
  logic [2:0]  CC_MEM;
  logic        BR_VALID;
  logic [15:0] BR_TARGET;
  logic        UNALIGNED;

  // Producer of EX results and consumer of MEM results (pipeline neighbours / bench)
  modport master (
    output V_EX, RESULT, OP_EX_RETURN, DR_EX_RETURN, CC, STORE_DATA, FLUSH,
    input  STALL, V_MEM, OP_MEM, DR_MEM, DATA_MEM, CC_MEM, BR_VALID, BR_TARGET, UNALIGNED
  );

  // The memory stage itself
  modport slave (
    input  V_EX, RESULT, OP_EX_RETURN, DR_EX_RETURN, CC, STORE_DATA, FLUSH,
    output STALL, V_MEM, OP_MEM, DR_MEM, DATA_MEM, CC_MEM, BR_VALID, BR_TARGET, UNALIGNED
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: 256x16 data RAM, ADD/BR pass-through, LDW/STW access, branch redirect to fetch.
// Latency: ADD/BR/STW 1 cycle; aligned LDW 2 cycles (one LD_WAIT bubble).
// Backpressure: STALL=1 during LD_WAIT, upstream holds; FLUSH drops in-flight and incoming work.
// Optional: define MEM_ALIGN_CHECK_EN to flag odd-address LDW/STW via UNALIGNED.
module mem_stage (
  input  logic        CLK,
  input  logic        RST_N,
  mem_stage_if.slave  bus
);

  localparam logic [1:0] OP_BR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDW = 2'b10;
  localparam logic [1:0] OP_STW = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  ld_idx;      // word index captured when an LDW is accepted
  logic [15:0] ram [256];   // data memory, deliberately not reset

  logic        accept;
  logic [7:0]  word_idx;
  logic        misaligned;
  logic        ram_we;
  logic [15:0] ld_word;
  logic [2:0]  ld_cc;

  // NZP code of a loaded word
  function automatic logic [2:0] word_cc(input logic [15:0] w);
    if (w == 16'h0000)
      return 3'b010;
    else if (w[15])
      return 3'b100;
    else
      return 3'b001;
  endfunction

  // Hold upstream for exactly the load bubble
  assign bus.STALL = (state == LD_WAIT);

  // A new op is taken only when not stalled and not being flushed
  assign accept   = bus.V_EX && !bus.STALL && !bus.FLUSH;
  assign word_idx = bus.RESULT[8:1];

`ifdef MEM_ALIGN_CHECK_EN
  logic is_ldst;
  logic unaligned_q;

  assign is_ldst    = bus.OP_EX_RETURN[1];
  assign misaligned = is_ldst && bus.RESULT[0];

  // One-cycle misalignment pulse; accept already excludes FLUSH and LD_WAIT
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      unaligned_q <= 1'b0;
    else
      unaligned_q <= accept && misaligned;
  end

  assign bus.UNALIGNED = unaligned_q;
`else
  assign misaligned    = 1'b0;
  assign bus.UNALIGNED = 1'b0;
`endif

  // Stores commit on the accepting edge; a later flush does not roll them back
  assign ram_we = accept && (bus.OP_EX_RETURN == OP_STW) && !misaligned;

  // Read port is only consumed in LD_WAIT, when no write can occur
  assign ld_word = ram[ld_idx];
  assign ld_cc   = word_cc(ld_word);

  // RAM write port
  always_ff @(posedge CLK) begin
    if (ram_we)
      ram[word_idx] <= bus.STORE_DATA;
  end

  // Stage FSM and registered WB / branch outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      ld_idx        <= 8'h00;
      bus.V_MEM     <= 1'b0;
      bus.OP_MEM    <= 2'b00;
      bus.DR_MEM    <= 3'b000;
      bus.DATA_MEM  <= 16'h0000;
      bus.CC_MEM    <= 3'b000;
      bus.BR_VALID  <= 1'b0;
      bus.BR_TARGET <= 16'h0000;
    end else if (bus.FLUSH) begin
      // Abort any pending load and drop the incoming op
      state        <= IDLE;
      bus.V_MEM    <= 1'b0;
      bus.BR_VALID <= 1'b0;
    end else begin
      case (state)
        LD_WAIT: begin
          state        <= IDLE;
          bus.V_MEM    <= 1'b1;
          bus.DATA_MEM <= ld_word;
          bus.CC_MEM   <= ld_cc;
          bus.BR_VALID <= 1'b0;
        end
        default: begin
          if (accept) begin
            bus.OP_MEM   <= bus.OP_EX_RETURN;
            bus.DR_MEM   <= bus.DR_EX_RETURN;
            bus.BR_VALID <= 1'b0;
            bus.V_MEM    <= 1'b1;
            bus.CC_MEM   <= bus.CC;
            case (bus.OP_EX_RETURN)
              OP_BR: begin
                bus.BR_VALID  <= 1'b1;
                bus.BR_TARGET <= bus.RESULT;
              end
              OP_ADD: begin
                bus.DATA_MEM <= bus.RESULT;
              end
              OP_STW: begin
                bus.DATA_MEM <= misaligned ? 16'h0000 : bus.STORE_DATA;
              end
              default: begin // OP_LDW
                if (misaligned) begin
                  bus.DATA_MEM <= 16'h0000;
                end else begin
                  bus.V_MEM <= 1'b0;
                  ld_idx    <= word_idx;
                  state     <= LD_WAIT;
                end
              end
            endcase
          end else begin
            bus.V_MEM    <= 1'b0;
            bus.BR_VALID <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts post-edge outputs from pre-edge inputs; compares at posedge+1.
// Backpressure: stimulus keeps toggling V_EX under STALL; the model ignores it there.
module tb_mem_stage;

  localparam logic [1:0] BR  = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] LDW = 2'b10;
  localparam logic [1:0] STW = 2'b11;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  mem_stage_if bus ();

  mem_stage dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: memory image plus expected outputs
  logic [15:0] m_ram   [256];
  bit          m_known [256];
  bit          m_pend;
  logic [7:0]  m_addr;

  logic        e_v, e_br, e_una;
  logic [1:0]  e_op;
  logic [2:0]  e_dr, e_cc;
  logic [15:0] e_data, e_tgt;
  bit          e_data_ok, e_cc_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_align(input logic [1:0] op, input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return op[1] && a[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pend = 0; m_addr = 0;
    e_v = 0; e_br = 0; e_una = 0; e_op = 0; e_dr = 0; e_cc = 0;
    e_data = 0; e_tgt = 0; e_data_ok = 1; e_cc_ok = 1;
  endtask

  // What the outputs must be after the next edge, given the current inputs
  task automatic model_edge();
    logic [15:0] w;
    if (bus.FLUSH) begin
      e_v = 0; e_br = 0; e_una = 0; m_pend = 0;
    end else if (m_pend) begin
      m_pend = 0; e_v = 1; e_br = 0; e_una = 0;
      w = m_ram[m_addr];
      e_data = w;
      e_cc = (w == 16'h0) ? 3'b010 : (w[15] ? 3'b100 : 3'b001);
      e_data_ok = m_known[m_addr];
      e_cc_ok = m_known[m_addr];
    end else if (bus.V_EX) begin
      e_op = bus.OP_EX_RETURN; e_dr = bus.DR_EX_RETURN;
      e_v = 1; e_br = 0; e_una = 0;
      e_cc = bus.CC; e_cc_ok = 1;
      if (bad_align(bus.OP_EX_RETURN, bus.RESULT)) begin
        e_una = 1; e_data = 16'h0; e_data_ok = 1;
      end else begin
        case (bus.OP_EX_RETURN)
          BR:  begin e_br = 1; e_tgt = bus.RESULT; e_data_ok = 0; end
          ADD: begin e_data = bus.RESULT; e_data_ok = 1; end
          STW: begin
            m_ram[bus.RESULT[8:1]] = bus.STORE_DATA;
            m_known[bus.RESULT[8:1]] = 1;
            e_data = bus.STORE_DATA; e_data_ok = 1;
          end
          default: begin
            e_v = 0; m_pend = 1; m_addr = bus.RESULT[8:1];
            e_data_ok = 0; e_cc_ok = 0;
          end
        endcase
      end
    end else begin
      e_v = 0; e_br = 0; e_una = 0;
    end
  endtask

  task automatic compare();
    chk("stall", bus.STALL, m_pend);
    chk("v_mem", bus.V_MEM, e_v);
    chk("br_valid", bus.BR_VALID, e_br);
    chk("unaligned", bus.UNALIGNED, e_una);
    chk("op_mem", bus.OP_MEM, e_op);
    chk("dr_mem", bus.DR_MEM, e_dr);
    chk("br_target", bus.BR_TARGET, e_tgt);
    if (e_data_ok) chk("data_mem", bus.DATA_MEM, e_data);
    if (e_cc_ok)   chk("cc_mem", bus.CC_MEM, e_cc);
  endtask

  // Drive one cycle of inputs, predict, clock, compare
  task automatic step(input bit v, input logic [15:0] res, input logic [1:0] op,
                      input logic [2:0] dr, input logic [2:0] cc, input logic [15:0] sd,
                      input bit fl);
    bus.V_EX = v; bus.RESULT = res; bus.OP_EX_RETURN = op; bus.DR_EX_RETURN = dr;
    bus.CC = cc; bus.STORE_DATA = sd; bus.FLUSH = fl;
    #1;
    chk("stall_pre", bus.STALL, m_pend);
    model_edge();
    @(posedge CLK);
    #1;
    compare();
  endtask

  task automatic idle();
    step(0, 16'h0, ADD, 3'd0, 3'd0, 16'h0, 0);
  endtask

  initial begin
    logic [15:0] r, d;
    for (int i = 0; i < 256; i++) begin m_ram[i] = 0; m_known[i] = 0; end
    model_reset();
    bus.V_EX = 0; bus.RESULT = 0; bus.OP_EX_RETURN = 0; bus.DR_EX_RETURN = 0;
    bus.CC = 0; bus.STORE_DATA = 0; bus.FLUSH = 0;

    // Reset state
    #3;
    chk("rst_v_mem", bus.V_MEM, 0);
    chk("rst_stall", bus.STALL, 0);
    chk("rst_br_valid", bus.BR_VALID, 0);
    chk("rst_data", bus.DATA_MEM, 0);
    chk("rst_target", bus.BR_TARGET, 0);
    #9 RST_N = 1;

    // Store then load back through the bubble
    step(1, 16'h0010, STW, 3'd1, 3'b001, 16'hBEEF, 0);
    step(1, 16'h0010, LDW, 3'd2, 3'b001, 16'h0, 0);
    chk("ld_stall", bus.STALL, 1);
    chk("ld_bubble_v", bus.V_MEM, 0);
    idle();
    chk("ld_v", bus.V_MEM, 1);
    chk("ld_data", bus.DATA_MEM, 16'hBEEF);
    chk("ld_cc", bus.CC_MEM, 3'b100);
    chk("ld_stall_done", bus.STALL, 0);

    // ADD of zero
    step(1, 16'h0000, ADD, 3'd3, 3'b010, 16'h0, 0);
    chk("add_v", bus.V_MEM, 1);
    chk("add_data", bus.DATA_MEM, 16'h0);
    chk("add_cc", bus.CC_MEM, 3'b010);
    chk("add_dr", bus.DR_MEM, 3'd3);
    chk("add_stall", bus.STALL, 0);

    // Branch redirect is a single-cycle pulse
    step(1, 16'h3002, BR, 3'd0, 3'b001, 16'h0, 0);
    chk("br_valid", bus.BR_VALID, 1);
    chk("br_target", bus.BR_TARGET, 16'h3002);
    idle();
    chk("br_pulse_end", bus.BR_VALID, 0);

    // Flush during LD_WAIT kills the load
    step(1, 16'h0020, LDW, 3'd4, 3'b001, 16'h0, 0);
    step(1, 16'h0040, ADD, 3'd5, 3'b001, 16'h0, 1);
    chk("flush_v", bus.V_MEM, 0);
    chk("flush_stall", bus.STALL, 0);
    idle();
    chk("flush_no_pulse", bus.V_MEM, 0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store is flagged and does not touch memory
    step(1, 16'h0010, STW, 3'd1, 3'b001, 16'h5A5A, 0);
    step(1, 16'h0011, STW, 3'd1, 3'b001, 16'h1234, 0);
    chk("una_flag", bus.UNALIGNED, 1);
    chk("una_v", bus.V_MEM, 1);
    chk("una_data", bus.DATA_MEM, 16'h0);
    step(1, 16'h0010, LDW, 3'd2, 3'b001, 16'h0, 0);
    idle();
    chk("una_old_data", bus.DATA_MEM, 16'h5A5A);
    chk("una_clear", bus.UNALIGNED, 0);
`endif

    // Reset asserted mid-LD_WAIT
    step(1, 16'h0010, LDW, 3'd6, 3'b001, 16'h0, 0);
    #2 RST_N = 0;
    #1;
    chk("arst_v", bus.V_MEM, 0);
    chk("arst_stall", bus.STALL, 0);
    chk("arst_op", bus.OP_MEM, 0);
    chk("arst_dr", bus.DR_MEM, 0);
    chk("arst_data", bus.DATA_MEM, 0);
    chk("arst_cc", bus.CC_MEM, 0);
    chk("arst_br", bus.BR_VALID, 0);
    chk("arst_una", bus.UNALIGNED, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1;
    idle();
    chk("post_rst_v", bus.V_MEM, 0);
    idle();
    chk("post_rst_v2", bus.V_MEM, 0);

    // Randomized traffic over a small address window to force reuse
    for (int n = 0; n < 3000; n++) begin
      r = 16'($urandom);
      r[8:1] = 8'($urandom_range(0, 15));
      r[0] = ($urandom % 4 == 0);
      case ($urandom % 4)
        0:       d = 16'h0000;
        1:       d = {1'b1, 15'($urandom)};
        default: d = 16'($urandom);
      endcase
      step(($urandom % 4) != 0, r, 2'($urandom), 3'($urandom), 3'($urandom), d,
           ($urandom % 12) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
